// File: rtl/gb_cpu_sched_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gb_cpu_sched_sequencer
// Brief    : Latches a decoded M-cycle schedule and issues one control word
//            per M-cycle, with condition short-cut and fetch-overlap loading.
// Revision : 1.0
// ============================================================================
module gb_cpu_sched_sequencer #(
  parameter int                DEPTH    = 6,
  parameter int                CTRL_W   = 96,
  parameter int                LEN_W    = $clog2(DEPTH + 1),
  parameter logic [CTRL_W-1:0] NOP_WORD = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_tick,
  input  logic                    load,
  input  logic [DEPTH*CTRL_W-1:0] sched_ctrl,
  input  logic [LEN_W-1:0]        sched_len,
  input  logic [DEPTH-1:0]        sched_cc_mask,
  input  logic [1:0]              sched_cond,
  input  logic                    sched_cb,
  input  logic                    flag_z,
  input  logic                    flag_c,
  output logic [CTRL_W-1:0]       ctrl_out,
  output logic [LEN_W-1:0]        slot_idx,
  output logic                    busy,
  output logic                    last_slot,
  output logic                    done,
  output logic                    cond_fail,
  output logic                    cb_pending,
  output logic                    load_drop
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] C_DEPTH = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] C_ONE   = LEN_W'(1);

  state_t            r_state, w_state_nxt;
  logic [CTRL_W-1:0] r_words [DEPTH];
  logic [LEN_W-1:0]  r_len, r_slot, w_slot_nxt, w_len_in;
  logic [DEPTH-1:0]  r_mask;
  logic [1:0]        r_cond;
  logic              r_cb, w_cb_nxt;
  logic              r_done, w_done_nxt;
  logic              r_cond_fail, w_cond_fail_nxt;
  logic              r_drop, w_drop_nxt;
  logic              w_last, w_accept, w_cond_true, w_mask_bit;
  logic [CTRL_W-1:0] w_word;

  assign w_len_in   = (sched_len > C_DEPTH) ? C_DEPTH : sched_len;
  assign w_last     = (r_state == ST_RUN) && (r_slot == r_len - C_ONE);
  assign w_mask_bit = |(r_mask & (DEPTH'(1) << r_slot));
  // A new schedule may only land while idle or on the retire tick of the current one.
  assign w_accept   = load && (sched_len != '0) &&
                      ((r_state == ST_IDLE) || (w_last && m_tick));

  always_comb begin
    case (r_cond)
      2'b00:   w_cond_true = !flag_z;
      2'b01:   w_cond_true = flag_z;
      2'b10:   w_cond_true = !flag_c;
      default: w_cond_true = flag_c;
    endcase
  end

  always_comb begin
    w_word = NOP_WORD;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_slot == LEN_W'(k)) w_word = r_words[k];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_cb_nxt        = r_cb;
    w_done_nxt      = 1'b0;
    w_cond_fail_nxt = 1'b0;
    w_drop_nxt      = load && !w_accept;
    if ((r_state == ST_RUN) && m_tick) begin
      if (w_last) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
        w_slot_nxt  = '0;
        w_cb_nxt    = 1'b0;
      end else if (w_mask_bit && !w_cond_true) begin
        w_slot_nxt      = r_len - C_ONE;
        w_cond_fail_nxt = 1'b1;
      end else begin
        w_slot_nxt = r_slot + C_ONE;
      end
    end
    if (w_accept) begin
      w_state_nxt = ST_RUN;
      w_slot_nxt  = '0;
      w_cb_nxt    = sched_cb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_cb        <= 1'b0;
      r_done      <= 1'b0;
      r_cond_fail <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_cb        <= w_cb_nxt;
      r_done      <= w_done_nxt;
      r_cond_fail <= w_cond_fail_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_mask <= '0;
      r_cond <= '0;
      for (int k = 0; k < DEPTH; k++) r_words[k] <= '0;
    end else if (w_accept) begin
      r_len  <= w_len_in;
      r_mask <= sched_cc_mask;
      r_cond <= sched_cond;
      for (int k = 0; k < DEPTH; k++) r_words[k] <= sched_ctrl[k*CTRL_W +: CTRL_W];
    end
  end

  assign ctrl_out   = (r_state == ST_RUN) ? w_word : NOP_WORD;
  assign slot_idx   = r_slot;
  assign busy       = (r_state == ST_RUN);
  assign last_slot  = w_last;
  assign done       = r_done;
  assign cond_fail  = r_cond_fail;
  assign cb_pending = r_cb;
  assign load_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_gb_cpu_sched_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_cpu_sched_sequencer
// Brief    : Directed self-checking bench for the M-cycle sequencer (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_gb_cpu_sched_sequencer;

  localparam int          DEPTH  = 4;
  localparam int          CTRL_W = 16;
  localparam int          LEN_W  = 3;
  localparam logic [15:0] NOP    = 16'h0F0F;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    m_tick = 1'b0;
  logic                    load = 1'b0;
  logic [DEPTH*CTRL_W-1:0] sched_ctrl = '0;
  logic [LEN_W-1:0]        sched_len = '0;
  logic [DEPTH-1:0]        sched_cc_mask = '0;
  logic [1:0]              sched_cond = '0;
  logic                    sched_cb = 1'b0;
  logic                    flag_z = 1'b0;
  logic                    flag_c = 1'b0;
  logic [CTRL_W-1:0]       ctrl_out;
  logic [LEN_W-1:0]        slot_idx;
  logic                    busy, last_slot, done, cond_fail, cb_pending, load_drop;

  int n_checks = 0;
  int n_fail   = 0;

  gb_cpu_sched_sequencer #(
    .DEPTH   (DEPTH),
    .CTRL_W  (CTRL_W),
    .LEN_W   (LEN_W),
    .NOP_WORD(NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_tick       (m_tick),
    .load         (load),
    .sched_ctrl   (sched_ctrl),
    .sched_len    (sched_len),
    .sched_cc_mask(sched_cc_mask),
    .sched_cond   (sched_cond),
    .sched_cb     (sched_cb),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .ctrl_out     (ctrl_out),
    .slot_idx     (slot_idx),
    .busy         (busy),
    .last_slot    (last_slot),
    .done         (done),
    .cond_fail    (cond_fail),
    .cb_pending   (cb_pending),
    .load_drop    (load_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3,
                          input logic [2:0] len, input logic [3:0] mask,
                          input logic [1:0] cond, input logic cb);
    sched_ctrl    = {w3, w2, w1, w0};
    sched_len     = len;
    sched_cc_mask = mask;
    sched_cond    = cond;
    sched_cb      = cb;
    load          = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] wv [4];
    int          ticks;

    // reset state
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_ctrl", ctrl_out, NOP);
    check("rst_slot", slot_idx, 0);
    check("rst_pulses", {done, cond_fail, load_drop, cb_pending, last_slot}, 0);
    rst_n = 1'b1;
    step();

    // plain run, m_tick every 4 clks
    wv[0] = 16'hA001; wv[1] = 16'hB002; wv[2] = 16'hC003; wv[3] = 16'h0000;
    set_load(wv[0], wv[1], wv[2], wv[3], 3'd3, 4'b0000, 2'b00, 1'b0);
    step();
    load = 1'b0;
    check("plain_busy", busy, 1);
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("plain_ctrl_s%0d_c%0d", s, c), ctrl_out, wv[s]);
        check($sformatf("plain_last_s%0d_c%0d", s, c), last_slot, (s == 2) ? 1 : 0);
        m_tick = (c == 3);
        step();
        if (c == 3) check($sformatf("plain_done_s%0d", s), done, (s == 2) ? 1 : 0);
      end
    end
    m_tick = 1'b0;
    check("plain_end_ctrl", ctrl_out, NOP);
    check("plain_end_busy", busy, 0);
    step();
    check("plain_done_clear", done, 0);

    // condition true: Z with flag_z=1 runs all slots
    flag_z = 1'b1;
    set_load(16'h1111, 16'h2222, 16'h3333, 16'h0, 3'd3, 4'b0001, 2'b01, 1'b0);
    step();
    load = 1'b0; m_tick = 1'b1;
    step();
    check("ctt_slot1", slot_idx, 1);
    check("ctt_nofail", cond_fail, 0);
    step();
    check("ctt_slot2", slot_idx, 2);
    step();
    check("ctt_done", done, 1);
    m_tick = 1'b0;

    // condition false: slot 0 jumps to final slot
    flag_z = 1'b0;
    set_load(16'h1111, 16'h2222, 16'h3333, 16'h0, 3'd3, 4'b0001, 2'b01, 1'b0);
    step();
    load = 1'b0;
    check("ctf_slot0", slot_idx, 0);
    m_tick = 1'b1;
    step();
    check("ctf_slot", slot_idx, 2);
    check("ctf_fail", cond_fail, 1);
    check("ctf_ctrl", ctrl_out, 16'h3333);
    check("ctf_last", last_slot, 1);
    check("ctf_nodone", done, 0);
    step();
    check("ctf_done", done, 1);
    check("ctf_fail_once", cond_fail, 0);
    check("ctf_idle", busy, 0);
    m_tick = 1'b0;

    // back-to-back load on the retire tick
    set_load(16'h4444, 16'h5555, 16'h6666, 16'h0, 3'd3, 4'b0000, 2'b00, 1'b0);
    step();
    load = 1'b0; m_tick = 1'b1;
    step(); step();
    check("b2b_old_last", ctrl_out, 16'h6666);
    set_load(16'hD00D, 16'hE00E, 16'h0, 16'h0, 3'd2, 4'b0000, 2'b00, 1'b1);
    step();
    load = 1'b0;
    check("b2b_done", done, 1);
    check("b2b_ctrl", ctrl_out, 16'hD00D);
    check("b2b_busy", busy, 1);
    check("b2b_cb", cb_pending, 1);
    check("b2b_nodrop", load_drop, 0);
    check("b2b_slot", slot_idx, 0);
    step();
    check("b2b_ctrl1", ctrl_out, 16'hE00E);
    check("b2b_last1", last_slot, 1);
    step();
    check("b2b_done2", done, 1);
    check("b2b_cb_clear", cb_pending, 0);
    check("b2b_idle", busy, 0);
    m_tick = 1'b0;

    // dropped load mid-run, then a 20-clk stall
    set_load(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 3'd4, 4'b0000, 2'b00, 1'b0);
    step();
    load = 1'b0; m_tick = 1'b1;
    step();
    m_tick = 1'b0;
    set_load(16'hFFFF, 16'hEEEE, 16'h0, 16'h0, 3'd2, 4'b0000, 2'b00, 1'b1);
    step();
    load = 1'b0;
    check("drop_pulse", load_drop, 1);
    check("drop_slot", slot_idx, 1);
    check("drop_ctrl", ctrl_out, 16'h0B0B);
    check("drop_cb", cb_pending, 0);
    step();
    check("drop_clear", load_drop, 0);
    m_tick = 1'b1;
    step();
    m_tick = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("stall_slot", slot_idx, 2);
    check("stall_ctrl", ctrl_out, 16'h0C0C);
    m_tick = 1'b1;
    step();
    check("resume_ctrl", ctrl_out, 16'h0D0D);
    check("resume_last", last_slot, 1);
    step();
    check("resume_done", done, 1);
    m_tick = 1'b0;

    // zero length is dropped
    set_load(16'h1234, 16'h0, 16'h0, 16'h0, 3'd0, 4'b0000, 2'b00, 1'b0);
    step();
    load = 1'b0;
    check("len0_drop", load_drop, 1);
    check("len0_idle", busy, 0);

    // length beyond DEPTH clamps to DEPTH
    wv[0] = 16'h7001; wv[1] = 16'h7002; wv[2] = 16'h7003; wv[3] = 16'h7004;
    set_load(wv[0], wv[1], wv[2], wv[3], 3'd7, 4'b0000, 2'b00, 1'b0);
    step();
    load = 1'b0;
    ticks = 0;
    m_tick = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (!busy) break;
      check($sformatf("clamp_ctrl_%0d", t), ctrl_out, wv[t % 4]);
      step();
      ticks++;
      if (done) break;
    end
    m_tick = 1'b0;
    check("clamp_ticks", ticks, 4);
    check("clamp_idle", busy, 0);

    // asynchronous reset mid-run
    set_load(16'h9001, 16'h9002, 16'h9003, 16'h9004, 3'd4, 4'b0000, 2'b00, 1'b1);
    step();
    load = 1'b0; m_tick = 1'b1;
    step(); step();
    check("mid_pre_slot", slot_idx, 2);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_ctrl", ctrl_out, NOP);
    check("mid_slot", slot_idx, 0);
    check("mid_cb", cb_pending, 0);
    step();
    check("mid_nodone", done, 0);
    m_tick = 1'b0;
    rst_n = 1'b1;
    step();
    check("mid_post_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gb_cpu_sched_sequencer.md
Name: gb_cpu_sched_sequencer

Overview:
Parametrised M-cycle instruction sequencer for the GameBoy CPU core. It latches a decoded schedule of up to DEPTH control words. It then presents one word per M-cycle to the datapath (regfile, ALU, IDU, bus), cutting the schedule short when a condition-code check fails. It generalises the fixed 6-slot schedule to arbitrary depth and control-word width, adding back-to-back (fetch-overlap) loading and per-slot condition evaluation.

Parameters:
DEPTH, 6, maximum number of M-cycle slots per schedule (2..16)
CTRL_W, 96, width of one packed control word
LEN_W, $clog2(DEPTH+1), width of the length field
NOP_WORD, '0, control word driven while idle

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
m_tick  in  1  one-clk strobe marking an M-cycle boundary; the sequencer advances only on it
load  in  1  new schedule valid
sched_ctrl  in  DEPTH*CTRL_W  slot words; slot k = bits [k*CTRL_W +: CTRL_W]
sched_len  in  LEN_W  number of slots used (m_cycles)
sched_cc_mask  in  DEPTH  bit k=1: evaluate the condition at the end of slot k
sched_cond  in  2  condition code: 00 NZ, 01 Z, 10 NC, 11 C
sched_cb  in  1  next opcode is 0xCB-prefixed
flag_z  in  1  live Z flag
flag_c  in  1  live C flag
ctrl_out  out  CTRL_W  control word for the current M-cycle
slot_idx  out  LEN_W  current slot index
busy  out  1  schedule executing
last_slot  out  1  current slot is the final one (fetch overlap)
done  out  1  one-clk pulse on the m_tick that retires the final slot
cond_fail  out  1  one-clk pulse when a checked condition is false
cb_pending  out  1  latched sched_cb of the active schedule
load_drop  out  1  one-clk pulse: load ignored

Behaviour:
- Reset (async, rst_n=0): state IDLE. ctrl_out=NOP_WORD. slot_idx=0. busy, last_slot, done, cond_fail, cb_pending and load_drop all =0. Stored schedule cleared. Reset mid-schedule aborts immediately; no done pulse.
- States: IDLE, RUN.
- Load acceptance:
  - Accepted when IDLE, or when RUN with last_slot=1 and m_tick=1 in the same clk.
  - On acceptance: latch ctrl, len, mask, cond and cb; slot_idx<=0; state RUN.
  - ctrl_out shows slot 0 from the next clk.
  - Load in any other cycle is ignored and pulses load_drop.
- Length rules:
  - sched_len=0: load ignored, load_drop pulses.
  - sched_len>DEPTH: clamped to DEPTH.
- Outputs in RUN:
  - ctrl_out = stored slot[slot_idx]; it is stable between m_ticks.
  - last_slot = (slot_idx == len-1), purely from registered state.
- Advance (RUN, m_tick=1, not last slot):
  - If mask[slot_idx]=1 and the condition is false, slot_idx<=len-1 (jump to the final/fetch slot) and cond_fail pulses.
  - Otherwise slot_idx<=slot_idx+1.
  - Condition truth: NZ=!flag_z, Z=flag_z, NC=!flag_c, C=flag_c, sampled in that clk.
- Retire (RUN, m_tick=1, last slot): done pulses.
  - If load is also accepted, the new schedule starts with no idle gap, and cb_pending takes the new sched_cb.
  - Otherwise state IDLE, ctrl_out=NOP_WORD, cb_pending<=0.
- mask bit on the final slot is ignored.
- len=1: the first m_tick retires; back-to-back loads give one M-cycle per instruction.
- m_tick=0: all state holds; load in IDLE is still accepted.

Test Plan:
- Reset mid-run: load len=4 and advance 2 m_ticks, then assert rst_n=0 -> immediately busy=0, ctrl_out=NOP_WORD, slot_idx=0, no done pulse.
- Plain run: load len=3 with words A,B,C; m_tick every 4 clks -> ctrl_out shows A,B,C for 4 clks each; last_slot asserts with C; done pulses on the 3rd m_tick; then ctrl_out=NOP_WORD and busy=0.
- Condition true vs. false: load len=3 with mask=001 and cond=Z.
  - With flag_z=1 -> slots 0,1,2 execute.
  - With flag_z=0 -> slot 0 jumps to slot 2, cond_fail pulses once, done on the 2nd m_tick.
- Back-to-back loads: a load with len=2 and sched_cb=1 lands on the retire m_tick of the prior schedule -> ctrl_out goes from the old final word to the new slot 0 with no NOP; done=1 in that clk; cb_pending=1.
- Dropped and edge loads:
  - Load at slot 1 of a len=4 run -> load_drop=1 and the schedule is unaffected.
  - sched_len=0 -> load_drop=1 and the block stays idle.
  - sched_len=DEPTH+3 -> runs exactly DEPTH slots.
- Stall: hold m_tick=0 for 20 clks mid-run -> ctrl_out and slot_idx unchanged; resuming continues from the same slot.
